// File: rtl/uart_pkg.sv
// Shared constants, feeder state encoding and parity helper for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 11;   // start + 8 data + parity + stop

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        GAP  = 3'd4
    } feeder_state_t;

    // Even parity is the XOR of all data bits; odd parity is its complement.
    function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bundle of the write-side and serializer-side signals of the transmit feeder.
// master: local write logic plus serializer; slave: the feeder itself.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    // Write side
    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   full;
    logic [LEVEL_W-1:0]     level;
    logic                   overflow;
    logic                   ovf_clr;

    // Serializer side
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_parity;
    logic                   tx_send;
    logic                   tx_active;
    logic                   tx_done;

    modport master (
        output wr_en, wr_data, ovf_clr, tx_active, tx_done,
        input  full, level, overflow, tx_data, tx_parity, tx_send
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, tx_active, tx_done,
        output full, level, overflow, tx_data, tx_parity, tx_send
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO holding bytes waiting for the serializer. The head entry is
// read combinationally so the consumer can register it on the pop edge; a
// write into an empty FIFO only becomes visible the following cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     baud_clk,
    input  logic                     reset_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_reg == LW'(DEPTH));
    assign empty = (count_reg == '0);
    assign level = count_reg;

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    assign rd_data = mem[rd_ptr_reg];

    // Storage array; not reset, contents only meaningful between the pointers.
    always_ff @(posedge baud_clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; count tracks net change.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + LW'(1);
                2'b01:   count_reg <= count_reg - LW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Upstream stage of the UART transmitter: queues bytes, attaches parity and
// hands one byte at a time to the serializer with a send/active/done handshake.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PARITY_ODD = 0,
    parameter int GAP_BITS   = 1
) (
    input  logic             baud_clk,
    input  logic             reset_n,
    uart_tx_feeder_if.slave  bus,
    output logic             busy,
    output logic             frame_sent
);
    localparam int   LEVEL_W  = $clog2(DEPTH) + 1;
    localparam logic PAR_ODD  = (PARITY_ODD != 0);
    localparam logic HAS_GAP  = (GAP_BITS > 0);
    localparam logic [3:0] GAP_LAST = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    feeder_state_t          state_reg, state_next;
    logic [UART_DATA_W-1:0] tx_data_reg, tx_data_next;
    logic                   tx_parity_reg, tx_parity_next;
    logic                   tx_send_reg, tx_send_next;
    logic                   frame_sent_reg, frame_sent_next;
    logic [3:0]             gap_cnt_reg, gap_cnt_next;
    logic                   overflow_reg;
    logic                   pop;

    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LEVEL_W-1:0]     fifo_level;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .wr       (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd       (pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign bus.full      = fifo_full;
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow_reg;
    assign bus.tx_data   = tx_data_reg;
    assign bus.tx_parity = tx_parity_reg;
    assign bus.tx_send   = tx_send_reg;
    assign busy          = (state_reg != IDLE);
    assign frame_sent    = frame_sent_reg;

    // State and registered outputs; reset drops send so the next send is a clean rising edge.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            tx_data_reg    <= '0;
            tx_parity_reg  <= PAR_ODD;
            tx_send_reg    <= 1'b0;
            frame_sent_reg <= 1'b0;
            gap_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            tx_data_reg    <= tx_data_next;
            tx_parity_reg  <= tx_parity_next;
            tx_send_reg    <= tx_send_next;
            frame_sent_reg <= frame_sent_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    // Next-state logic; tx_data/tx_parity only move on a pop in IDLE.
    always_comb begin
        state_next      = state_reg;
        tx_data_next    = tx_data_reg;
        tx_parity_next  = tx_parity_reg;
        tx_send_next    = tx_send_reg;
        frame_sent_next = 1'b0;
        gap_cnt_next    = gap_cnt_reg;
        pop             = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_send_next = 1'b0;
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    tx_data_next   = fifo_rd_data;
                    tx_parity_next = calc_parity(fifo_rd_data, PAR_ODD);
                    state_next     = LOAD;
                end
            end
            LOAD: begin
                tx_send_next = 1'b1;
                state_next   = SEND;
            end
            SEND: begin
                // Only leaving SEND after active is seen means WAIT never acts on a stale done.
                if (bus.tx_active) begin
                    tx_send_next = 1'b0;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (!bus.tx_active && bus.tx_done) begin
                    frame_sent_next = 1'b1;
                    gap_cnt_next    = '0;
                    state_next      = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next   = IDLE;
                tx_send_next = 1'b0;
            end
        endcase
    end

    // Sticky overflow on a dropped write; an explicit clear takes priority.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (bus.ovf_clr) begin
            overflow_reg <= 1'b0;
        end else if (bus.wr_en && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural serializer and line receiver.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH      = 4;
    localparam int PARITY_ODD = 0;
    localparam int GAP_BITS   = 1;
    // Feeder/serializer round trip beyond the 11 line bits: done seen, IDLE pop,
    // LOAD raises send, then two cycles until the serializer drives the start bit.
    localparam int HANDSHAKE  = 5;
    localparam int PERIOD     = UART_FRAME_BITS + HANDSHAKE + GAP_BITS;

    logic baud_clk = 1'b0;
    logic reset_n;
    logic busy;
    logic frame_sent;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus();

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .PARITY_ODD (PARITY_ODD),
        .GAP_BITS   (GAP_BITS)
    ) dut (
        .baud_clk   (baud_clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .busy       (busy),
        .frame_sent (frame_sent)
    );

    always #5 baud_clk = ~baud_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Behavioural serializer: active 2 cycles after send rises, 11 bits LSB first,
    // then active drops and done stays high until the next frame starts.
    logic       send_q, pending, ser_active, ser_done, line;
    logic [9:0] shreg;
    int         bit_cnt;

    always @(posedge baud_clk) begin
        if (!reset_n) begin
            send_q     <= 1'b0;
            pending    <= 1'b0;
            ser_active <= 1'b0;
            ser_done   <= 1'b0;
            line       <= 1'b1;
            shreg      <= '0;
            bit_cnt    <= 0;
        end else begin
            send_q  <= bus.tx_send;
            pending <= bus.tx_send && !send_q && !ser_active && !pending;
            if (pending) begin
                ser_active <= 1'b1;
                ser_done   <= 1'b0;
                line       <= 1'b0;
                shreg      <= {1'b1, bus.tx_parity, bus.tx_data};
                bit_cnt    <= 1;
            end else if (ser_active) begin
                if (bit_cnt == UART_FRAME_BITS) begin
                    ser_active <= 1'b0;
                    ser_done   <= 1'b1;
                    line       <= 1'b1;
                end else begin
                    line    <= shreg[0];
                    shreg   <= {1'b0, shreg[9:1]};
                    bit_cnt <= bit_cnt + 1;
                end
            end
        end
    end

    assign bus.tx_active = ser_active;
    assign bus.tx_done   = ser_done;

    // Line receiver and frame_sent counter, sampling on the falling edge.
    logic [10:0] rx_bits;
    int          rx_idx;
    int          rx_start_cyc;
    logic [7:0]  rx_data_q[$];
    logic        rx_par_q[$];
    logic        rx_ok_q[$];
    int          rx_start_q[$];
    int          fs_count;

    initial begin
        rx_idx       = 0;
        rx_start_cyc = 0;
        fs_count     = 0;
        rx_bits      = '0;
        forever begin
            @(negedge baud_clk);
            if (frame_sent) fs_count++;
            if (!reset_n) begin
                rx_idx = 0;
            end else if (ser_active) begin
                if (rx_idx == 0) rx_start_cyc = cyc;
                if (rx_idx < 11) rx_bits[rx_idx] = line;
                rx_idx++;
            end else if (rx_idx != 0) begin
                rx_data_q.push_back(rx_bits[8:1]);
                rx_par_q.push_back(rx_bits[9]);
                rx_ok_q.push_back(!rx_bits[0] && rx_bits[10] && (rx_idx == 11));
                rx_start_q.push_back(rx_start_cyc);
                rx_idx = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Advance to just after the next falling edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(negedge baud_clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (rx_data_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, rx_data_q.size(), n);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fs0;
        int found;
        int stable_err;
        int early;
        int seen_rise;
        int seen_fall;
        logic [7:0] exp_seq[6];

        vecs[0] = '{data: 8'h55, par: 1'b0};
        vecs[1] = '{data: 8'h01, par: 1'b1};
        vecs[2] = '{data: 8'h80, par: 1'b1};
        vecs[3] = '{data: 8'hFF, par: 1'b0};
        vecs[4] = '{data: 8'h3C, par: 1'b0};
        vecs[5] = '{data: 8'h7F, par: 1'b1};

        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ovf_clr = 1'b0;
        repeat (3) tick();

        check("rst_level", bus.level, 0);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_parity", bus.tx_parity, PARITY_ODD);
        check("rst_tx_send", bus.tx_send, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_sent", frame_sent, 0);

        reset_n = 1'b1;
        repeat (2) tick();

        // Single-byte frames from the vector table (first entry is 0x55, even parity 0).
        for (int i = 0; i < 6; i++) begin
            base = rx_data_q.size();
            fs0  = fs_count;
            write_byte(vecs[i].data);
            wait_frames(base + 1, 60, "vec_frame_count");
            repeat (3) tick();
            check("vec_line_data", rx_data_q[base], vecs[i].data);
            check("vec_line_parity", rx_par_q[base], vecs[i].par);
            check("vec_start_stop", rx_ok_q[base], 1);
            check("vec_tx_parity", bus.tx_parity, vecs[i].par);
            check("vec_frame_sent_pulses", fs_count - fs0, 1);
            check("vec_level_empty", bus.level, 0);
            check("vec_idle", busy, 0);
        end

        // Three bytes in consecutive cycles: ordered frames at the fixed back-to-back period.
        base = rx_data_q.size();
        fs0  = fs_count;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h01; tick();
        bus.wr_data = 8'h80; tick();
        bus.wr_data = 8'hFF; tick();
        bus.wr_en = 1'b0;
        wait_frames(base + 3, 150, "b2b_frame_count");
        repeat (3) tick();
        check("b2b_data0", rx_data_q[base],     8'h01);
        check("b2b_data1", rx_data_q[base + 1], 8'h80);
        check("b2b_data2", rx_data_q[base + 2], 8'hFF);
        check("b2b_par0", rx_par_q[base],     1);
        check("b2b_par1", rx_par_q[base + 1], 1);
        check("b2b_par2", rx_par_q[base + 2], 0);
        check("b2b_period01", rx_start_q[base + 1] - rx_start_q[base],     PERIOD);
        check("b2b_period12", rx_start_q[base + 2] - rx_start_q[base + 1], PERIOD);
        check("b2b_frame_sent", fs_count - fs0, 3);

        // Six writes while idle into a 4-deep FIFO: one popped, four held, one dropped.
        base = rx_data_q.size();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_data = 8'h10 + 8'(i);
            tick();
        end
        check("ovf_level", bus.level, DEPTH);
        check("ovf_full", bus.full, 1);
        check("ovf_set", bus.overflow, 1);
        // Dropped write and clear in the same cycle: clear wins.
        bus.wr_data = 8'h16;
        bus.ovf_clr = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        check("ovf_clear_wins", bus.overflow, 0);
        check("ovf_level_hold", bus.level, DEPTH);
        wait_frames(base + 5, 200, "ovf_frame_count");
        repeat (20) tick();
        check("ovf_no_extra_frame", rx_data_q.size(), base + 5);
        for (int i = 0; i < 5; i++) begin
            check("ovf_data", rx_data_q[base + i], 8'h10 + i);
        end

        // Full FIFO with a pop and a write in the same cycle.
        base = rx_data_q.size();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = 8'h20 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("fullpop_pre_full", bus.full, 1);
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            tick();
            if (!busy) found = 1;
        end
        check("fullpop_reached_idle", found, 1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h25;
        tick();
        bus.wr_en   = 1'b0;
        check("fullpop_level", bus.level, DEPTH);
        check("fullpop_overflow", bus.overflow, 0);
        wait_frames(base + 6, 250, "fullpop_frame_count");
        for (int i = 0; i < 6; i++) exp_seq[i] = 8'h20 + 8'(i);
        for (int i = 0; i < 6; i++) begin
            check("fullpop_data", rx_data_q[base + i], exp_seq[i]);
        end
        repeat (4) tick();

        // Stale done from the previous frame must not complete the next one.
        base       = rx_data_q.size();
        fs0        = fs_count;
        stable_err = 0;
        early      = 0;
        seen_rise  = 0;
        seen_fall  = 0;
        found      = 0;
        write_byte(8'hA3);
        for (int k = 0; k < 60 && found == 0; k++) begin
            tick();
            if (ser_active) seen_rise = 1;
            if (seen_rise != 0 && !ser_active) seen_fall = 1;
            if (busy && bus.tx_data !== 8'hA3) stable_err++;
            if (frame_sent) begin
                found = 1;
                if (seen_fall == 0) early = 1;
            end
        end
        check("stale_frame_sent_seen", found, 1);
        check("stale_not_early", early, 0);
        check("stale_tx_data_stable_errs", stable_err, 0);
        repeat (3) tick();
        check("stale_line_data", rx_data_q[base], 8'hA3);
        check("stale_line_parity", rx_par_q[base], 0);
        check("stale_frame_sent_pulses", fs_count - fs0, 1);

        // Reset in WAIT with two bytes queued.
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h40; tick();
        bus.wr_data = 8'h42; tick();
        bus.wr_data = 8'h43; tick();
        bus.wr_en = 1'b0;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            tick();
            if (busy && bus.tx_active && !bus.tx_send) found = 1;
        end
        check("rstmid_reached_wait", found, 1);
        repeat (2) tick();
        check("rstmid_pre_level", bus.level, 2);
        base    = rx_data_q.size();
        reset_n = 1'b0;
        #1;
        check("rstmid_level", bus.level, 0);
        check("rstmid_full", bus.full, 0);
        check("rstmid_overflow", bus.overflow, 0);
        check("rstmid_tx_data", bus.tx_data, 0);
        check("rstmid_tx_parity", bus.tx_parity, PARITY_ODD);
        check("rstmid_tx_send", bus.tx_send, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_frame_sent", frame_sent, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        check("rstmid_no_stale_frames", rx_data_q.size(), base);
        fs0 = fs_count;
        write_byte(8'h3C);
        wait_frames(base + 1, 60, "rstmid_frame_count");
        repeat (30) tick();
        check("rstmid_single_frame", rx_data_q.size(), base + 1);
        check("rstmid_data", rx_data_q[base], 8'h3C);
        check("rstmid_parity", rx_par_q[base], 0);
        check("rstmid_start_stop", rx_ok_q[base], 1);
        check("rstmid_frame_sent", fs_count - fs0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
